fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the MIPS-31 pipeline. It owns the PC, issues word fetches to instruction memory over a ready handshake, and presents the fetched instruction to ID. It supplies the delay-slot PC to the ID-stage branch resolver and consumes that resolver's redirect decision with MIPS branch-delay-slot semantics: the instruction already in IF always executes. A skid/hold buffer and a pending-redirect register keep fetch correct across memory wait states and hazard stalls.

## Interface
- `RESET_PC`, 32'h0040_0000, PC value loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req` out 1: fetch request for `imem_addr`.
- `imem_addr` out 32: word address being fetched, always equal to `pc_out`.
- `imem_rdata` in 32: instruction; valid when `imem_req & imem_ready`.
- `imem_ready` in 1: fetch completes this cycle.
- `stall` in 1: hazard-unit stall; holds PC and IF/ID.
- `is_branch` in 1: ID resolver says redirect (taken branch, j/jal, jr/jalr).
- `branch_pc` in 32: redirect target from ID.
- `pc_out` out 32: address of instruction in IF, i.e. the delay-slot PC fed back to ID.
- `id_instr` out 32: IF/ID instruction.
- `id_pc` out 32: IF/ID instruction address.
- `id_valid` out 1: IF/ID holds a real instruction, not a bubble.

## Operation
- Registers: `pc`, `state` {S_REQ, S_HELD}, `hold_instr`, `redir_pending`, `redir_pc`, and IF/ID {`id_instr`, `id_pc`, `id_valid`}.
- `imem_req = (state==S_REQ) & ~rst`. `imem_addr = pc_out = pc`.
- `br_now = is_branch & id_valid & ~stall`. The branch is consumed only in the cycle its ID instruction advances.
- `next_pc = br_now ? branch_pc : redir_pending ? redir_pc : pc + 4`. Use 32-bit modular add. Bits [1:0] of the loaded value are forced to 00.
- `advance` = S_REQ & imem_ready & ~stall, or S_HELD & ~stall. On advance:
  - IF/ID loads {instr, pc, 1}, where instr is `imem_rdata` in S_REQ and `hold_instr` in S_HELD.
  - `pc <= next_pc`.
  - `redir_pending <= 0`.
  - Next state is S_REQ.
- S_REQ & imem_ready & stall: `hold_instr <= imem_rdata`, go to S_HELD. There is no refetch; `imem_req` drops while held.
- S_HELD & stall: stay in S_HELD, hold everything.
- No advance & ~stall: IF/ID loads a bubble {32'h0, 32'h0, 0}. If `br_now`, set `redir_pending <= 1` and `redir_pc <= branch_pc`. PC holds, so the delay slot is still fetched first.
- `stall`: IF/ID, `pc` and the redirect registers hold. `is_branch` is ignored.
- `br_now` and `redir_pending` are never both set. While a redirect is pending, ID holds only bubbles. If both are set anyway, `br_now` wins.
- Memory contract: `imem_ready` is meaningful only while `imem_req` is high. Dropping `imem_req` (hold, reset) abandons nothing outstanding.

## Timing
- Reset values:
  - `pc` = RESET_PC, `state` = S_REQ.
  - `id_instr` = 0, `id_pc` = 0, `id_valid` = 0.
  - `redir_pending` = 0, `redir_pc` = 0, `hold_instr` = 0.
  - `imem_req` = 0 while `rst` is high, 1 from the first cycle after release.
- Fetch-to-ID latency is 1 cycle. Throughput is 1 instr/cycle with `imem_ready` high and no stall.
- Branch in ID at cycle N, fetch completing in N: `imem_addr` = target at N+1, and the delay slot appears in ID at N+1.
- Wrap: pc 0xFFFF_FFFC advances to 0x0000_0000 with no flag.
- Reset mid-operation (S_HELD, redirect pending, wait state) clears all state asynchronously. The held instruction and pending redirect are discarded.

## Structure
- A shared package holds the `RESET_PC` default, `NOP_INSTR` = 32'h0, and the `fetch_state_t` encoding (S_REQ=0, S_HELD=1).
- One natural sub-module is `fetch_redirect_reg`, which holds `redir_pending`/`redir_pc` and computes `next_pc`. The FSM and IF/ID register stay in the top.

## Test plan
- Reset release, `imem_ready`=1, no stall: `imem_addr` is 0x00400000, 0x00400004, 0x00400008 on consecutive cycles. `id_pc` lags by 1 cycle with `id_valid`=1.
- Taken beq at 0x00400000 in ID with target 0x00400020, IF fetching 0x00400004, ready=1: the next `imem_addr` is 0x00400020, and ID gets 0x00400004 (delay slot) then 0x00400020.
- Same branch with `imem_ready` low for 3 cycles: ID shows 3 bubbles (`id_valid`=0) and `redir_pending`=1. After ready, the delay slot 0x00400004 enters ID and `imem_addr` is 0x00400020, not 0x00400008.
- `stall` high while ready=1 at pc 0x00400010: `imem_req`=0 next cycle and IF/ID is unchanged for 2 stall cycles. On release, the held instruction with `id_pc` 0x00400010 enters ID, with no second fetch of 0x00400010.
- Redirect to branch_pc 0xFFFF_FFFE: `pc` = 0xFFFF_FFFC, then advances to 0x0000_0000.
- `rst` asserted while in S_HELD with a redirect pending: all outputs return to reset values immediately, and the first post-reset `imem_addr` is 0x00400000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_stage_pkg                                                  |
// | Brief    : Shared constants and FSM encoding for the MIPS-31 fetch stage.   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;

    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t S_REQ  = 1'b0;
    localparam fetch_state_t S_HELD = 1'b1;

    // Fetches are word-aligned; redirect targets may carry junk in [1:0].
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_redirect_reg                                               |
// | Brief    : Pending-redirect register and next-PC selection for fetch.       |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_redirect_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_pc,
    input  logic        i_br_now,
    input  logic [31:0] i_branch_pc,
    input  logic        i_advance,
    output logic [31:0] o_next_pc,
    output logic        o_redir_pending
);

    logic        r_redir_pending;
    logic [31:0] r_redir_pc;
    logic [31:0] w_sel_pc;
    logic        w_capture;

    // A branch resolved while the delay slot is still being fetched must be
    // remembered until that delay slot finally advances.
    assign w_capture = i_br_now & ~i_advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redir_pending <= 1'b0;
            r_redir_pc      <= 32'h0000_0000;
        end else if (i_advance) begin
            r_redir_pending <= 1'b0;
        end else if (w_capture) begin
            r_redir_pending <= 1'b1;
            r_redir_pc      <= i_branch_pc;
        end
    end

    always_comb begin
        w_sel_pc = i_pc + PC_STEP;
        if (i_br_now) begin
            w_sel_pc = i_branch_pc;
        end else if (r_redir_pending) begin
            w_sel_pc = r_redir_pc;
        end
    end

    assign o_next_pc       = word_align(w_sel_pc);
    assign o_redir_pending = r_redir_pending;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_stage                                                      |
// | Brief    : MIPS-31 instruction fetch with delay-slot redirect and IF/ID reg. |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        is_branch,
    input  logic [31:0] branch_pc,
    output logic [31:0] pc_out,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_valid
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_hold_instr;
    logic [31:0]  r_id_instr;
    logic [31:0]  r_id_pc;
    logic         r_id_valid;

    logic         w_in_req;
    logic         w_in_held;
    logic         w_br_now;
    logic         w_advance;
    logic         w_hold;
    logic [31:0]  w_fetch_instr;
    logic [31:0]  w_next_pc;
    logic         w_redir_pending;

    assign w_in_req  = (r_state == S_REQ);
    assign w_in_held = (r_state == S_HELD);

    // The resolver's decision belongs to the ID instruction, so it only counts
    // in the cycle that instruction actually leaves ID.
    assign w_br_now  = is_branch & r_id_valid & ~stall;

    assign w_advance = (w_in_req & imem_ready & ~stall) | (w_in_held & ~stall);
    assign w_hold    = w_in_req & imem_ready & stall;

    assign w_fetch_instr = w_in_held ? r_hold_instr : imem_rdata;

    fetch_redirect_reg u_redirect (
        .clk             (clk),
        .rst             (rst),
        .i_pc            (r_pc),
        .i_br_now        (w_br_now),
        .i_branch_pc     (branch_pc),
        .i_advance       (w_advance),
        .o_next_pc       (w_next_pc),
        .o_redir_pending (w_redir_pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_hold_instr <= NOP_INSTR;
        end else if (w_advance) begin
            r_state <= S_REQ;
            r_pc    <= w_next_pc;
        end else if (w_hold) begin
            // The completed fetch is parked here; memory is not asked again.
            r_state      <= S_HELD;
            r_hold_instr <= imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_instr <= NOP_INSTR;
            r_id_pc    <= 32'h0000_0000;
            r_id_valid <= 1'b0;
        end else if (w_advance) begin
            r_id_instr <= w_fetch_instr;
            r_id_pc    <= r_pc;
            r_id_valid <= 1'b1;
        end else if (!stall) begin
            r_id_instr <= NOP_INSTR;
            r_id_pc    <= 32'h0000_0000;
            r_id_valid <= 1'b0;
        end
    end

    assign imem_req  = w_in_req & ~rst;
    assign imem_addr = r_pc;
    assign pc_out    = r_pc;
    assign id_instr  = r_id_instr;
    assign id_pc     = r_id_pc;
    assign id_valid  = r_id_valid;

    // Kept visible for debug hierarchy; ID never sees a branch while it is set.
    logic w_unused_pending;
    assign w_unused_pending = w_redir_pending;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_stage                                                   |
// | Brief    : Directed table-driven bench for fetch_stage.                     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

    localparam logic [31:0] K_MEM   = 32'hC0DE_0000;
    localparam logic [31:0] BAD_MEM = 32'hBAD0_BAD0;
    localparam int          NVEC    = 17;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        is_branch;
    logic [31:0] branch_pc;
    logic [31:0] pc_out;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;

    int checks;
    int errors;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        br;
        logic [31:0] bpc;
        logic [31:0] e_addr;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [NVEC];

    // Memory returns a tag derived from the address, and garbage when not asked.
    assign imem_rdata = imem_req ? (imem_addr ^ K_MEM) : BAD_MEM;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .stall      (stall),
        .is_branch  (is_branch),
        .branch_pc  (branch_pc),
        .pc_out     (pc_out),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_valid   (id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] e_addr, input logic e_req,
                                 input logic e_valid, input logic [31:0] e_pc);
        logic [31:0] e_instr;
        e_instr = e_valid ? (e_pc ^ K_MEM) : 32'h0;
        check({tag, ".imem_addr"}, imem_addr, e_addr);
        check({tag, ".pc_out"},    pc_out,    e_addr);
        check({tag, ".imem_req"},  {31'h0, imem_req}, {31'h0, e_req});
        check({tag, ".id_valid"},  {31'h0, id_valid}, {31'h0, e_valid});
        check({tag, ".id_pc"},     id_pc,     e_pc);
        check({tag, ".id_instr"},  id_instr,  e_instr);
    endtask

    task automatic step(input logic s, input logic r, input logic b, input logic [31:0] bpc);
        stall      = s;
        imem_ready = r;
        is_branch  = b;
        branch_pc  = bpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // stall ready br bpc | addr after edge, req, id_valid, id_pc
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0040_0004, 1'b1, 1'b1, 32'h0040_0000};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h0040_0020, 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0004};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0040_0024, 1'b1, 1'b1, 32'h0040_0020};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0040_0080, 32'h0040_0024, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h0040_0024, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0040_0024, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0040_0080, 1'b1, 1'b1, 32'h0040_0024};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0040_0084, 1'b1, 1'b1, 32'h0040_0080};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h0040_0084, 1'b0, 1'b1, 32'h0040_0080};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h0040_0084, 1'b0, 1'b1, 32'h0040_0080};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0040_0084, 1'b0, 1'b1, 32'h0040_0080};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0040_0088, 1'b1, 1'b1, 32'h0040_0084};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h0040_0100, 32'h0040_0088, 1'b1, 1'b1, 32'h0040_0084};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0040_008C, 1'b1, 1'b1, 32'h0040_0088};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0040_008C};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFC};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0004, 1'b1, 1'b1, 32'h0000_0000};

        rst        = 1'b1;
        stall      = 1'b0;
        imem_ready = 1'b0;
        is_branch  = 1'b0;
        branch_pc  = 32'h0;
        #12;
        check_outputs("reset", 32'h0040_0000, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_outputs("release", 32'h0040_0000, 1'b1, 1'b0, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].stall, vecs[i].ready, vecs[i].br, vecs[i].bpc);
            check_outputs($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_req,
                          vecs[i].e_valid, vecs[i].e_pc);
        end

        // Park a redirect and a held fetch, then reset asynchronously mid-cycle.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        check_outputs("pend", 32'h0000_0004, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check_outputs("held", 32'h0000_0004, 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 32'h0040_0000, 1'b0, 1'b0, 32'h0);
        stall      = 1'b0;
        imem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_outputs("rst_release", 32'h0040_0000, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check_outputs("post_rst0", 32'h0040_0004, 1'b1, 1'b1, 32'h0040_0000);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check_outputs("post_rst1", 32'h0040_0008, 1'b1, 1'b1, 32'h0040_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
